nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle WIDTH-bit adder that sits directly upstream of the team's 4-bit carry-lookahead slice. It accepts a wide operand pair through a valid/ready handshake and feeds the CLA slice one nibble per clock, least-significant nibble first, with the carry registered between nibbles. It then presents the assembled sum, carry-out and signed overflow on a valid/ready output handshake. This trades latency for area: one 4-bit CLA serves any multiple-of-4 width.

## Interface
- WIDTH, 16: operand and sum width; must be a multiple of 4 and at least 8.
- clk  input  1  rising-edge clock; the only clock in the block.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair is present.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A; sampled on the accept edge only.
- b  input  WIDTH  operand B; sampled on the accept edge only.
- cin  input  1  carry-in; sampled on the accept edge.
- sub  input  1  subtract request; present only with SUBTRACT_EN.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement overflow, computed as carry-into-MSB XOR cout.

## Operation
- States: IDLE, RUN, DONE. NIB = WIDTH/4. Nibble index idx is $clog2(NIB) bits wide.
- IDLE:
  - in_ready = 1.
  - When in_valid && in_ready at an edge: latch a, b and cin (carry register ← cin), set idx ← 0, go to RUN.
- RUN, at each edge:
  - The slice adds a_r[4*idx+:4], b_r[4*idx+:4] and the carry register.
  - The result is written to sum[4*idx+:4]. The carry register ← slice co.
  - idx ← idx+1.
  - At the edge where idx == NIB-1: cout ← co, ovf ← c3 ^ co, out_valid ← 1, go to DONE.
- DONE:
  - sum, cout and ovf are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid ← 0, go to IDLE.
- in_valid is ignored outside IDLE. Operands are not re-sampled mid-operation, so later input changes have no effect.
- Arithmetic:
  - sum = (a + b + cin) mod 2^WIDTH.
  - cout = bit WIDTH of the full sum.
  - No saturation.
- Reset, in any state including mid-RUN:
  - State → IDLE, idx = 0, carry register = 0.
  - sum = 0, cout = 0, ovf = 0, out_valid = 0.
  - The in-flight operation is discarded.
  - in_ready reads 1 while reset is held; handshakes during reset are ignored.
- sum bits not yet written during RUN are undefined to observers and are qualified by out_valid.

## Timing
- Accept edge = T0. out_valid rises at edge T0+NIB (4 edges for WIDTH=16).
- Output handshake edge Th: in_ready is high from Th onward. The next accept is possible at Th+1 at the earliest.
- Peak throughput is one operation per NIB+2 cycles.
- There is no combinational path from inputs to outputs. in_ready is decoded from state only.

## Configuration
- SUBTRACT_EN defined:
  - The sub port exists and is latched on the accept edge.
  - When sub = 1, B is inverted and carry-in is forced to 1, so cin is ignored. The result is a − b.
  - cout = 1 means no borrow. ovf is the signed subtraction overflow.
- SUBTRACT_EN undefined: the sub port is absent and the block is addition-only.

## Structure
- Package nibble_add_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the constant NIB_W = 4.
- One sub-module, cla4_slice:
  - Inputs: a4, b4, ci.
  - Outputs: s4, co, and c3 (carry into bit 3, used for ovf).
  - Combinational lookahead logic, instantiated once.

## Test plan
1. a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, ovf=0. out_valid rises exactly 4 edges after accept.
2. a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Checks carry crossing every nibble boundary.
3. a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0, ovf=1.
4. Backpressure:
   - Stimulus: hold out_ready=0 for 3 cycles after out_valid, and drive in_valid=1 with new operands throughout.
   - Response: sum, cout and ovf are stable; in_ready=0; the new operands are not accepted until the cycle after the output handshake.
5. Reset mid-operation:
   - Stimulus: assert rst 2 cycles into RUN.
   - Response: out_valid=0, sum=0 immediately (asynchronous); in_ready=1. The next operation, a=0x0001, b=0x0001, gives sum=0x0002.
6. SUBTRACT_EN build:
   - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0, ovf=0.
   - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// The optional SUBTRACT_EN build adds the subtract path.
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int NIB_W = 4;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The sub signal exists only when SUBTRACT_EN is defined.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SUBTRACT_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SUBTRACT_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`endif

endinterface

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3,
// exposed so the caller can form signed overflow.
module cla4_slice
  import nibble_add_pkg::*;
(
  input  logic [NIB_W-1:0] a4,
  input  logic [NIB_W-1:0] b4,
  input  logic             ci,
  output logic [NIB_W-1:0] s4,
  output logic             co,
  output logic             c3
);

  logic [NIB_W-1:0] w_g;
  logic [NIB_W-1:0] w_p;
  logic             w_c1;
  logic             w_c2;

  assign w_g = a4 & b4;
  assign w_p = a4 ^ b4;

  // Flattened lookahead: every carry is a sum of products of g/p and ci.
  assign w_c1 = w_g[0] | (w_p[0] & ci);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign c3   = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign co   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

  assign s4 = w_p ^ {c3, w_c2, w_c1, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams operands through one 4-bit CLA slice,
// LS nibble first. Define SUBTRACT_EN to enable the a - b mode.
module nibble_serial_adder
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic               r_outValid;

  logic [NIB_W-1:0]   w_a4;
  logic [NIB_W-1:0]   w_b4;
  logic [NIB_W-1:0]   w_s4;
  logic               w_co;
  logic               w_c3;

  assign w_a4 = r_a[NIB_W*r_idx +: NIB_W];
  assign w_b4 = r_b[NIB_W*r_idx +: NIB_W];

  cla4_slice u_slice (
    .a4 (w_a4),
    .b4 (w_b4),
    .ci (r_carry),
    .s4 (w_s4),
    .co (w_co),
    .c3 (w_c3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a   <= bus.a;
            r_idx <= '0;
`ifdef SUBTRACT_EN
            // Subtraction is a + ~b + 1, so B is inverted once at accept time.
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub | bus.cin;
`else
            r_b     <= bus.b;
            r_carry <= bus.cin;
`endif
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[NIB_W*r_idx +: NIB_W] <= w_s4;
          r_carry <= w_co;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_cout     <= w_co;
            r_ovf      <= w_c3 ^ w_co;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_outValid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=16);
// the subtract vectors are compiled in when SUBTRACT_EN is defined.
module tb_nibble_serial_adder;

  logic clk;
  logic rst;
  int   testCount;
  int   failCount;

  nibble_serial_adder_if #(.WIDTH(16)) ifc ();

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one operand pair and returns #1 after the accept edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub);
    ifc.a        = a;
    ifc.b        = b;
    ifc.cin      = cin;
`ifdef SUBTRACT_EN
    ifc.sub      = sub;
`endif
    ifc.in_valid = 1'b1;
    check("in_ready_before_accept", {31'b0, ifc.in_ready}, 32'h1);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    if (sub) begin
    end
  endtask

  // Counts edges until out_valid rises, bounded so a stuck DUT still fails.
  task automatic waitResult(input string tag, input int expEdges);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ifc.out_valid && n < 20);
    check(tag, n, expEdges);
  endtask

  // Checks the held result, then completes the output handshake.
  task automatic checkOutput(input string tag, input logic [15:0] expSum,
                             input logic expCout, input logic expOvf);
    check({tag, "_sum"},  {16'b0, ifc.sum},  {16'b0, expSum});
    check({tag, "_cout"}, {31'b0, ifc.cout}, {31'b0, expCout});
    check({tag, "_ovf"},  {31'b0, ifc.ovf},  {31'b0, expOvf});
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'b0, ifc.out_valid}, 32'h0);
    check({tag, "_ready_back"}, {31'b0, ifc.in_ready},  32'h1);
  endtask

  initial begin
    testCount     = 0;
    failCount     = 0;
    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.cin       = 1'b0;
`ifdef SUBTRACT_EN
    ifc.sub       = 1'b0;
`endif
    ifc.out_ready = 1'b0;

    #12;
    check("rst_in_ready",  {31'b0, ifc.in_ready},  32'h1);
    check("rst_out_valid", {31'b0, ifc.out_valid}, 32'h0);
    check("rst_sum",       {16'b0, ifc.sum},       32'h0);
    check("rst_cout_ovf",  {30'b0, ifc.cout, ifc.ovf}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Plain add, also checks the NIB-edge latency.
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    waitResult("t1_latency", 4);
    checkOutput("t1", 16'h5555, 1'b0, 1'b0);

    // Carry ripples across every nibble boundary.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    waitResult("t2_latency", 4);
    checkOutput("t2", 16'h0000, 1'b1, 1'b0);

    // Carry-in pushes into the sign bit.
    applyStimulus(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    waitResult("t3_latency", 4);
    checkOutput("t3", 16'h8000, 1'b0, 1'b1);

    // Backpressure with new operands waiting on the input side.
    applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    waitResult("t4_latency", 4);
    ifc.a        = 16'h1111;
    ifc.b        = 16'h2222;
    ifc.cin      = 1'b0;
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t4_hold_sum",   {16'b0, ifc.sum},       32'h1010);
      check("t4_hold_flags", {30'b0, ifc.cout, ifc.ovf}, 32'h0);
      check("t4_hold_valid", {31'b0, ifc.out_valid}, 32'h1);
      check("t4_in_ready",   {31'b0, ifc.in_ready},  32'h0);
    end
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    check("t4_handshake_valid", {31'b0, ifc.out_valid}, 32'h0);
    check("t4_handshake_ready", {31'b0, ifc.in_ready},  32'h1);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    check("t4_accepted_next", {31'b0, ifc.in_ready}, 32'h0);
    waitResult("t4b_latency", 4);
    checkOutput("t4b", 16'h3333, 1'b0, 1'b0);

    // Asynchronous reset two cycles into RUN.
    applyStimulus(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_out_valid", {31'b0, ifc.out_valid}, 32'h0);
    check("t5_sum",       {16'b0, ifc.sum},       32'h0);
    check("t5_in_ready",  {31'b0, ifc.in_ready},  32'h1);
    ifc.a        = 16'h9999;
    ifc.b        = 16'h9999;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    check("t5_ignored_in_rst", {31'b0, ifc.in_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_idle_after_rst", {31'b0, ifc.out_valid}, 32'h0);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
    waitResult("t5b_latency", 4);
    checkOutput("t5b", 16'h0002, 1'b0, 1'b0);

`ifdef SUBTRACT_EN
    // Subtract: borrow case, then signed overflow case; cin is ignored.
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
    waitResult("t6a_latency", 4);
    checkOutput("t6a", 16'hFFFE, 1'b0, 1'b0);

    applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b1);
    waitResult("t6b_latency", 4);
    checkOutput("t6b", 16'h7FFF, 1'b1, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
